// File: rtl/vector_minmax_reduction_unit.sv
// Vector min/max reduction: folds vs2 beats, then lanes, then the scalar seed into one SEW element.
// execution_vector = {bit_mode[1:0] (0:SEW8 1:SEW16 2:SEW32 3:SEW64), sign_mode[1:0] (0:unsigned 1:signed), maximum_mode, minimum_mode}.
// Masking of inactive elements is enabled with `define VECTOR_REDUCTION_MASK_EN.
module vector_minmax_reduction_unit #(
    parameter int BEAT_COUNT_WIDTH = 6
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [5:0]                  execution_vector,
    input  logic                        start,
    input  logic [63:0]                 scalar_seed,
    input  logic [BEAT_COUNT_WIDTH-1:0] beat_count,
    input  logic                        beat_valid,
    output logic                        beat_ready,
    input  logic [63:0]                 beat_data,
    input  logic [7:0]                  beat_mask,
    output logic                        busy,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic [63:0]                 result
);

    typedef enum logic [2:0] {IDLE, ACCUMULATE, FOLD, SEED, DONE} state_t;

    state_t                      state_q, state_d;
    logic [63:0]                 acc_q, acc_d;
    logic [BEAT_COUNT_WIDTH-1:0] count_q, count_d;
    logic [1:0]                  fold_q, fold_d;
    logic [5:0]                  ev_q, ev_d;
    logic [63:0]                 seed_q, seed_d;

    logic [1:0]  sew;
    logic        is_signed;
    logic        is_max;
    logic [1:0]  fold_total;
    logic [5:0]  fold_shift;
    logic [63:0] lane_identity;
    logic [63:0] masked_data;

    // Operands are sign/zero-extended to 65 bits so one signed compare covers both modes.
    function automatic logic take_b(input logic [64:0] xa, input logic [64:0] xb, input logic want_max);
        if (want_max)
            return $signed(xb) > $signed(xa);
        else
            return $signed(xb) < $signed(xa);
    endfunction

    function automatic logic [63:0] lane_combine(input logic [63:0] a, input logic [63:0] b,
                                                 input logic [1:0] lane_sew, input logic sgn,
                                                 input logic want_max);
        logic [63:0] r;
        logic [64:0] xa;
        logic [64:0] xb;
        r = a;
        case (lane_sew)
            2'd0: for (int i = 0; i < 8; i++) begin
                xa = {{57{sgn & a[i*8+7]}}, a[i*8+:8]};
                xb = {{57{sgn & b[i*8+7]}}, b[i*8+:8]};
                if (take_b(xa, xb, want_max)) r[i*8+:8] = b[i*8+:8];
            end
            2'd1: for (int i = 0; i < 4; i++) begin
                xa = {{49{sgn & a[i*16+15]}}, a[i*16+:16]};
                xb = {{49{sgn & b[i*16+15]}}, b[i*16+:16]};
                if (take_b(xa, xb, want_max)) r[i*16+:16] = b[i*16+:16];
            end
            2'd2: for (int i = 0; i < 2; i++) begin
                xa = {{33{sgn & a[i*32+31]}}, a[i*32+:32]};
                xb = {{33{sgn & b[i*32+31]}}, b[i*32+:32]};
                if (take_b(xa, xb, want_max)) r[i*32+:32] = b[i*32+:32];
            end
            default: begin
                xa = {sgn & a[63], a};
                xb = {sgn & b[63], b};
                if (take_b(xa, xb, want_max)) r = b;
            end
        endcase
        return r;
    endfunction

    function automatic logic [63:0] lane_msbs(input logic [1:0] lane_sew);
        case (lane_sew)
            2'd0:    return 64'h8080_8080_8080_8080;
            2'd1:    return 64'h8000_8000_8000_8000;
            2'd2:    return 64'h8000_0000_8000_0000;
            default: return 64'h8000_0000_0000_0000;
        endcase
    endfunction

    function automatic logic [63:0] identity(input logic [5:0] ev);
        logic sgn;
        logic want_max;
        sgn      = (ev[3:2] == 2'b01);
        want_max = ev[1] & ~ev[0];
        if (sgn)
            return want_max ? lane_msbs(ev[5:4]) : ~lane_msbs(ev[5:4]);
        else
            return want_max ? 64'd0 : {64{1'b1}};
    endfunction

    function automatic logic [63:0] sew_mask(input logic [1:0] lane_sew);
        case (lane_sew)
            2'd0:    return 64'h0000_0000_0000_00FF;
            2'd1:    return 64'h0000_0000_0000_FFFF;
            2'd2:    return 64'h0000_0000_FFFF_FFFF;
            default: return {64{1'b1}};
        endcase
    endfunction

    assign sew           = ev_q[5:4];
    assign is_signed     = (ev_q[3:2] == 2'b01);
    assign is_max        = ev_q[1] & ~ev_q[0];
    assign fold_total    = 2'd3 - sew;
    assign fold_shift    = 6'd32 >> fold_q;
    assign lane_identity = identity(ev_q);

`ifdef VECTOR_REDUCTION_MASK_EN
    // Inactive lanes become the identity so they can never win the compare.
    always_comb begin
        masked_data = beat_data;
        case (sew)
            2'd0: for (int i = 0; i < 8; i++)
                if (!beat_mask[i]) masked_data[i*8+:8] = lane_identity[i*8+:8];
            2'd1: for (int i = 0; i < 4; i++)
                if (!beat_mask[i]) masked_data[i*16+:16] = lane_identity[i*16+:16];
            2'd2: for (int i = 0; i < 2; i++)
                if (!beat_mask[i]) masked_data[i*32+:32] = lane_identity[i*32+:32];
            default:
                if (!beat_mask[0]) masked_data = lane_identity;
        endcase
    end
`else
    logic mask_unused;
    assign mask_unused = ^{beat_mask, lane_identity};
    assign masked_data = beat_data;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        fold_d  = fold_q;
        ev_d    = ev_q;
        seed_d  = seed_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ev_d    = execution_vector;
                    seed_d  = scalar_seed;
                    count_d = beat_count;
                    acc_d   = identity(execution_vector);
                    fold_d  = 2'd0;
                    state_d = (beat_count != '0) ? ACCUMULATE : FOLD;
                end
            end
            ACCUMULATE: begin
                if (beat_valid) begin
                    acc_d   = lane_combine(acc_q, masked_data, sew, is_signed, is_max);
                    count_d = count_q - BEAT_COUNT_WIDTH'(1);
                    if (count_q == BEAT_COUNT_WIDTH'(1)) state_d = FOLD;
                end
            end
            // Each step halves the span of live lanes; SEW64 has nothing to fold and idles once.
            FOLD: begin
                if (fold_total == 2'd0) begin
                    state_d = SEED;
                end else begin
                    acc_d = lane_combine(acc_q, acc_q >> fold_shift, sew, is_signed, is_max);
                    if (fold_q == fold_total - 2'd1)
                        state_d = SEED;
                    else
                        fold_d = fold_q + 2'd1;
                end
            end
            SEED: begin
                acc_d   = lane_combine(acc_q, seed_q, sew, is_signed, is_max);
                state_d = DONE;
            end
            DONE: begin
                if (result_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            fold_q  <= '0;
            ev_q    <= '0;
            seed_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            fold_q  <= fold_d;
            ev_q    <= ev_d;
            seed_q  <= seed_d;
        end
    end

    assign beat_ready   = (state_q == ACCUMULATE);
    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == DONE);
    assign result       = acc_q & sew_mask(sew);

endmodule

// File: tb/tb_vector_minmax_reduction_unit.sv
// Directed self-checking bench for vector_minmax_reduction_unit with hand-computed results and latencies.
module tb_vector_minmax_reduction_unit;

    logic        clock;
    logic        reset;
    logic [5:0]  execution_vector;
    logic        start;
    logic [63:0] scalar_seed;
    logic [5:0]  beat_count;
    logic        beat_valid;
    logic        beat_ready;
    logic [63:0] beat_data;
    logic [7:0]  beat_mask;
    logic        busy;
    logic        result_valid;
    logic        result_ready;
    logic [63:0] result;

    int pass_count  = 0;
    int check_count = 0;

    logic [63:0] beat_tab [4];
    logic [7:0]  mask_tab [4];
    logic [63:0] masked_expect;

    vector_minmax_reduction_unit #(.BEAT_COUNT_WIDTH(6)) dut (
        .clock            (clock),
        .reset            (reset),
        .execution_vector (execution_vector),
        .start            (start),
        .scalar_seed      (scalar_seed),
        .beat_count       (beat_count),
        .beat_valid       (beat_valid),
        .beat_ready       (beat_ready),
        .beat_data        (beat_data),
        .beat_mask        (beat_mask),
        .busy             (busy),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .result           (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, observed, expected);
        else
            pass_count++;
    endtask

    // Runs one complete job from start through the result handshake; start is poked during the DONE hold.
    task automatic applyStimulus(input string tag, input logic [5:0] ev, input logic [63:0] seed,
                                 input int n, input logic [63:0] expected, input int exp_latency,
                                 input int hold);
        int   cycles;
        int   guard;
        logic ready_seen;
        execution_vector = ev;
        scalar_seed      = seed;
        beat_count       = 6'(n);
        start            = 1'b1;
        @(posedge clock); #1;
        start      = 1'b0;
        cycles     = 0;
        ready_seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            beat_data  = beat_tab[i];
            beat_mask  = mask_tab[i];
            beat_valid = 1'b1;
            guard      = 0;
            while (!beat_ready && guard < 20) begin
                @(posedge clock); #1;
                cycles++;
                guard++;
            end
            if (!beat_ready) checkOutput({tag, " beat timeout"}, 64'd0, 64'd1);
            @(posedge clock); #1;
            cycles++;
        end
        beat_valid = 1'b0;
        guard      = 0;
        while (!result_valid && guard < 50) begin
            ready_seen = ready_seen | beat_ready;
            @(posedge clock); #1;
            cycles++;
            guard++;
        end
        checkOutput({tag, " valid"}, 64'(result_valid), 64'd1);
        checkOutput({tag, " latency"}, 64'(cycles), 64'(exp_latency));
        checkOutput({tag, " result"}, result, expected);
        if (n == 0) checkOutput({tag, " no beat_ready"}, 64'(ready_seen), 64'd0);
        for (int h = 0; h < hold; h++) begin
            start            = 1'b1;
            execution_vector = ~ev;
            @(posedge clock); #1;
            checkOutput({tag, " held result"}, result, expected);
            checkOutput({tag, " held valid"}, 64'(result_valid), 64'd1);
        end
        start        = 1'b0;
        result_ready = 1'b1;
        @(posedge clock); #1;
        result_ready = 1'b0;
        checkOutput({tag, " idle busy"}, 64'(busy), 64'd0);
        checkOutput({tag, " idle valid"}, 64'(result_valid), 64'd0);
    endtask

    initial begin
        reset            = 1'b1;
        start            = 1'b0;
        execution_vector = '0;
        scalar_seed      = '0;
        beat_count       = '0;
        beat_valid       = 1'b0;
        beat_data        = '0;
        beat_mask        = 8'hFF;
        result_ready     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat_tab[i] = '0;
            mask_tab[i] = 8'hFF;
        end
        @(posedge clock); #1;
        @(posedge clock); #1;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset beat_ready", 64'(beat_ready), 64'd0);
        checkOutput("reset result_valid", 64'(result_valid), 64'd0);
        checkOutput("reset result", result, 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // SEW8 unsigned min, N=1: min lane 0x01, seed 0x09 -> 0x01; 1+3+1 edges.
        beat_tab[0] = 64'h0102_0304_0506_0708;
        applyStimulus("sew8_umin", 6'b00_00_0_1, 64'h09, 1, 64'h01, 5, 0);

        // SEW16 signed max, N=2: largest signed lane is 0x7000; 2+2+1 edges.
        beat_tab[0] = 64'hFFFF_0001_0002_0003;
        beat_tab[1] = 64'h8000_7000_0005_0004;
        applyStimulus("sew16_smax", 6'b01_01_1_0, 64'h0010, 2, 64'h7000, 5, 0);

        // SEW32 unsigned max, N=0: identity 0 vs seed; 0+1+1 edges, never ready.
        applyStimulus("sew32_umax_n0", 6'b10_00_1_0, 64'h1234_5678, 0, 64'h1234_5678, 2, 0);

        // SEW8 signed min; lane 7 (0x80) is masked off when masking is compiled in.
        beat_tab[0] = 64'h80FF_0000_0000_0005;
        mask_tab[0] = 8'h7F;
`ifdef VECTOR_REDUCTION_MASK_EN
        masked_expect = 64'hFF;
`else
        masked_expect = 64'h80;
`endif
        applyStimulus("sew8_smin_mask", 6'b00_01_0_1, 64'h03, 1, masked_expect, 5, 0);
        mask_tab[0] = 8'hFF;

        // Abort an N=4 job after two beats.
        execution_vector = 6'b00_00_1_0;
        scalar_seed      = 64'h01;
        beat_count       = 6'd4;
        start            = 1'b1;
        @(posedge clock); #1;
        start      = 1'b0;
        beat_data  = 64'h1111_1111_1111_1111;
        beat_valid = 1'b1;
        checkOutput("abort ready before", 64'(beat_ready), 64'd1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        beat_valid = 1'b0;
        reset      = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort beat_ready", 64'(beat_ready), 64'd0);
        checkOutput("abort result", result, 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            checkOutput("abort no valid", 64'(result_valid), 64'd0);
        end

        // SEW64 unsigned max after the abort: 1+1+1 edges.
        beat_tab[0] = 64'h5;
        applyStimulus("post_abort_sew64", 6'b11_00_1_0, 64'h3, 1, 64'h5, 3, 0);

        // SEW16 unsigned min with result_ready held low 5 cycles: min lane 0x0003.
        beat_tab[0] = 64'h0009_0003_0007_0005;
        applyStimulus("hold_sew16_umin", 6'b01_00_0_1, 64'h0004, 1, 64'h0003, 4, 5);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
